// File: rtl/fwd_select_unit.sv
// fwd_select_unit
//   Producer side of the EX-stage 3:1 operand-select muxes. Tracks destination
//   tags of the instructions in ID/EX, EX/MEM and MEM/WB, registers 2-bit
//   forwarding selects for ALU operands A and B, and raises the load-use stall.
//
//   Select encoding: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-low reset
//   id_*_i         decoded fields of the instruction currently in ID
//   flush_i        squash the ID instruction (taken branch/jump)
//   fwd_a_sel_o    operand A select for the instruction in EX
//   fwd_b_sel_o    operand B select for the instruction in EX
//   stall_o        load-use stall (combinational)
//   stall_cnt_o    stall-cycle counter
//
// Configuration
//   FWD_STALL_CNT_EN  when defined, stall_cnt_o counts stall cycles and
//                     saturates at all-ones; otherwise it is tied to zero.

module fwd_select_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic [REG_ADDR_W-1:0] dst;
    } tag_t;

    localparam logic [1:0] SelRf    = 2'b00;
    localparam logic [1:0] SelMemWb = 2'b01;
    localparam logic [1:0] SelExMem = 2'b10;

    tag_t idex_q, idex_d;
    tag_t exmem_q;
    tag_t memwb_q;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       bubble;

    // Register 0 is hard-wired, so it never counts as a matching writer.
    function automatic logic writer_match(tag_t t, logic [REG_ADDR_W-1:0] r);
        return t.valid & t.regwrite & (t.dst == r) & (r != '0);
    endfunction

    // The instruction in ID/EX now sits in EX/MEM once this one reaches EX,
    // hence IDEX maps to select 10 and EXMEM to 01. Younger writer wins.
    function automatic logic [1:0] sel_for(logic                  bub,
                                           logic                  use_r,
                                           logic [REG_ADDR_W-1:0] r,
                                           tag_t                  younger,
                                           tag_t                  older);
        if (bub || !use_r)             return SelRf;
        else if (writer_match(younger, r)) return SelExMem;
        else if (writer_match(older, r))   return SelMemWb;
        else                           return SelRf;
    endfunction

    always_comb begin
        stall_o = id_valid_i & ~flush_i & idex_q.memread &
                  ((id_use_rs_i & writer_match(idex_q, id_rs_i)) |
                   (id_use_rt_i & writer_match(idex_q, id_rt_i)));
        bubble  = ~id_valid_i | flush_i | stall_o;

        idex_d = '0;
        if (!bubble) begin
            idex_d.valid    = 1'b1;
            idex_d.regwrite = id_regwrite_i;
            idex_d.memread  = id_memread_i;
            idex_d.dst      = id_dst_i;
        end

        fwd_a_d = sel_for(bubble, id_use_rs_i, id_rs_i, idex_q, exmem_q);
        fwd_b_d = sel_for(bubble, id_use_rt_i, id_rt_i, idex_q, exmem_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            fwd_a_q <= SelRf;
            fwd_b_q <= SelRf;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= idex_q;
            memwb_q <= exmem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // MEM/WB is tracked for completeness of the pipeline view; its write lands
    // in the register file in the first half-cycle, so it never forwards.
    logic memwb_unused;
    assign memwb_unused = ^memwb_q;

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// tb_fwd_select_unit
//   Scoreboard bench for fwd_select_unit. The stimulus process keeps a history
//   of the instructions that entered EX and derives, from the hazard rules,
//   the expected stall and the selects/counter that must appear after the edge.
//   A monitor pops those expectations one cycle later and compares.

module tb_fwd_select_unit;

    localparam int unsigned AW      = 5;
    localparam int unsigned CW      = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          id_valid_i = 1'b0;
    logic [AW-1:0] id_rs_i = '0;
    logic [AW-1:0] id_rt_i = '0;
    logic          id_use_rs_i = 1'b0;
    logic          id_use_rt_i = 1'b0;
    logic [AW-1:0] id_dst_i = '0;
    logic          id_regwrite_i = 1'b0;
    logic          id_memread_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [1:0]    fwd_a_sel_o;
    logic [1:0]    fwd_b_sel_o;
    logic          stall_o;
    logic [CW-1:0] stall_cnt_o;

    fwd_select_unit #(
        .REG_ADDR_W(AW),
        .CNT_W     (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_use_rs_i  (id_use_rs_i),
        .id_use_rt_i  (id_use_rt_i),
        .id_dst_i     (id_dst_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i (id_memread_i),
        .flush_i      (flush_i),
        .fwd_a_sel_o  (fwd_a_sel_o),
        .fwd_b_sel_o  (fwd_b_sel_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int dst;
    } slot_t;

    typedef struct {
        int a;
        int b;
        int cnt;
    } exp_t;

    slot_t hist[$];   // instructions that entered EX, newest first
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    model_cnt = 0;
    bit    known = 0;

    function automatic slot_t at(int i);
        slot_t z;
        z.v = 0; z.rw = 0; z.mr = 0; z.dst = 0;
        if (i < hist.size()) return hist[i];
        return z;
    endfunction

    function automatic bit writes(slot_t s, int r);
        return s.v && s.rw && (s.dst == r) && (r != 0);
    endfunction

    // Operand source: the instruction one ahead will be in EX/MEM, two ahead
    // in MEM/WB; anything older is already in the register file.
    function automatic int sel(bit bub, bit use_r, int r);
        if (bub || !use_r)        return 0;
        if (writes(at(0), r))     return 2;
        if (writes(at(1), r))     return 1;
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit rst, bit v, int rs, int rt, bit urs, bit urt,
                        int dst, bit rw, bit mr, bit fl);
        exp_t  e;
        slot_t s;
        slot_t ex;
        bit    st;
        bit    bub;
        @(negedge clk_i);
        rst_i         = ~rst;
        id_valid_i    = v;
        id_rs_i       = AW'(rs);
        id_rt_i       = AW'(rt);
        id_use_rs_i   = urs;
        id_use_rt_i   = urt;
        id_dst_i      = AW'(dst);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #1;
        ex = at(0);
        st = v && !fl && ex.mr && ((urs && writes(ex, rs)) || (urt && writes(ex, rt)));
        if (known) check("stall", int'(stall_o), int'(st));
        if (rst) begin
            hist.delete();
            model_cnt = 0;
            e.a = 0; e.b = 0; e.cnt = 0;
            known = 1;
        end else begin
            bub = !v || fl || st;
            e.a = sel(bub, urs, rs);
            e.b = sel(bub, urt, rt);
`ifdef FWD_STALL_CNT_EN
            if (st && model_cnt < CNT_MAX) model_cnt++;
`endif
            e.cnt = model_cnt;
            s.v = !bub; s.rw = rw && !bub; s.mr = mr && !bub; s.dst = dst;
            hist.push_front(s);
            if (hist.size() > 3) void'(hist.pop_back());
        end
        exp_q.push_back(e);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge presents the selects for the instruction now in EX.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel_a", int'(fwd_a_sel_o), e.a);
                check("sel_b", int'(fwd_b_sel_o), e.b);
                check("stall_cnt", int'(stall_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        // Reset with a live instruction at the ID inputs.
        step(1, 1, 3, 3, 1, 1, 3, 1, 0, 0);
        step(1, 1, 3, 3, 1, 1, 3, 1, 0, 0);

        // EX/MEM forward on both operands.
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(0, 1, 5, 5, 1, 1, 9, 1, 0, 0);
        nop(); nop();

        // MEM/WB forward for r7, EX/MEM for r8.
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 8, 1, 0, 0);
        step(0, 1, 7, 8, 1, 1, 0, 0, 0, 0);
        nop(); nop();

        // Younger writer of r7 wins.
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        step(0, 1, 7, 0, 1, 0, 0, 0, 0, 0);
        nop(); nop();

        // Load-use: stall once, then re-present and take MEM/WB.
        step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(0, 1, 4, 0, 1, 0, 6, 1, 0, 0);
        step(0, 1, 4, 0, 1, 0, 6, 1, 0, 0);
        nop(); nop();

        // Load into r0 never stalls or forwards.
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 1, 1, 6, 1, 0, 0);
        nop(); nop();

        // Flush overrides the load-use stall.
        step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(0, 1, 4, 4, 1, 1, 6, 1, 0, 1);
        nop(); nop();

        // Five load-use stalls drive the counter into saturation.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
            step(0, 1, 2, 4, 1, 1, 6, 1, 0, 0);
            step(0, 1, 2, 4, 1, 1, 6, 1, 0, 0);
        end

        // Reset in the middle of a stall drops all in-flight tags.
        step(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(1, 1, 4, 4, 1, 1, 4, 1, 1, 0);
        step(0, 1, 4, 4, 1, 1, 0, 0, 0, 0);
        nop();

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 7),
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 8);
        end

        @(posedge clk_i);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_select_unit.md
Name: fwd_select_unit

Overview:
- Producer side of the 32-bit 3:1 operand-select mux in the pipelined CPU's EX stage.
- Tracks destination tags of in-flight instructions across the ID/EX, EX/MEM and MEM/WB stages.
- Drives registered 2-bit select codes for the ALU operand A and B muxes.
- Raises the load-use stall that holds PC and IF/ID and inserts a bubble.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, stall-counter width (used only with the optional feature).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  REG_ADDR_W  source register A of ID instruction.
- id_rt_i  in  REG_ADDR_W  source register B of ID instruction.
- id_use_rs_i  in  1  ID instruction reads rs.
- id_use_rt_i  in  1  ID instruction reads rt.
- id_dst_i  in  REG_ADDR_W  destination register of ID instruction.
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash ID instruction (taken branch/jump).
- fwd_a_sel_o  out  2  operand A select for the EX-stage instruction.
- fwd_b_sel_o  out  2  operand B select for the EX-stage instruction.
- stall_o  out  1  load-use stall request, combinational.
- stall_cnt_o  out  CNT_W  count of stall cycles.

Behaviour:
- Select encoding (matches mux data0/1/2):
  - 00 = register-file value.
  - 01 = MEM/WB result.
  - 10 = EX/MEM result.
  - 11 is never driven.
- Internal tag stages: IDEX, EXMEM, MEMWB, each holding {valid, regwrite, memread, dst}.
- "Writer X matches r" means X.valid & X.regwrite & X.dst==r & r!=0.
- stall_o = id_valid_i & !flush_i & IDEX.valid & IDEX.memread & IDEX.regwrite & IDEX.dst!=0 & ((id_use_rs_i & id_rs_i==IDEX.dst) | (id_use_rt_i & id_rt_i==IDEX.dst)).
- Each rising edge with rst_i=1:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= bubble (all zero) if !id_valid_i | flush_i | stall_o; otherwise the ID fields.
- fwd_a_sel_o registered on the same edge:
  - 00 if bubble or !id_use_rs_i.
  - Else 10 if IDEX (pre-edge) matches id_rs_i.
  - Else 01 if EXMEM (pre-edge) matches id_rs_i.
  - Else 00.
- fwd_b_sel_o: identical rule using id_rt_i and id_use_rt_i.
- Priority: the younger writer (EX/MEM) beats MEM/WB when both match.
- Selects are stable for exactly the one cycle the instruction occupies EX; latency from ID presentation to select = 1 cycle.
- Register 0 never forwards and never stalls.
- Load-use: stall lasts exactly 1 cycle. Next cycle the load sits in EXMEM, IDEX is a bubble, stall_o drops, and the re-presented instruction gets select 01 (load data from MEM/WB).
- flush_i overrides stall: flush_i=1 forces stall_o=0 and a bubble into IDEX, selects 00.
- Reset (rst_i=0 at edge): all tag stages invalid, fwd_a_sel_o=fwd_b_sel_o=00, stall_cnt_o=0. stall_o=0 the cycle after reset since IDEX is invalid.
- Reset mid-stall drops all in-flight tags; no forwarding from pre-reset instructions.
- The MEM/WB-to-ID same-cycle write is not forwarded; the register file writes in the first half-cycle.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: stall_cnt_o increments by 1 on each rising edge where stall_o=1; saturates at all-ones (no wrap); cleared by reset.
- Undefined: no counter logic; stall_cnt_o tied to 0.

Test Plan:
- Reset:
  - Stimulus: hold rst_i=0 for 2 cycles with id_valid_i=1, rs=3.
  - Response: sels=00, stall_o=0, stall_cnt_o=0 throughout.
- EX/MEM forward:
  - Stimulus: add r5 (regwrite) in ID, next cycle sub using rs=5, rt=5.
  - Response: cycle after sub enters EX, fwd_a_sel_o=10 and fwd_b_sel_o=10.
- MEM/WB forward with priority:
  - Stimulus: write r7; write r8; then use rs=7, rt=8.
  - Response: a=01, b=10.
  - Stimulus: r7 written twice back-to-back, then use rs=7.
  - Response: a=10.
- Load-use:
  - Stimulus: lw r4 then add rs=4.
  - Response: stall_o=1 for exactly 1 cycle; add then gets a=01; stall_cnt_o=1 with FWD_STALL_CNT_EN, 0 without.
- Register 0 and flush:
  - Stimulus: lw r0 then use rs=0.
  - Response: no stall, sel 00.
  - Stimulus: lw r4, then add rs=4 with flush_i=1.
  - Response: stall_o=0; next cycle sels 00.
- Counter saturation:
  - Stimulus: with FWD_STALL_CNT_EN and CNT_W=2, cause 5 load-use stalls.
  - Response: stall_cnt_o stays at 3.
